// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit arbiter.
//   state_e         : one-hot FSM encoding (S_IDLE, S_HDR, S_DATA)
//   HDR_SYNC_BYTE   : default sync byte carried in the header beat
//   HDR_*_LSB/_W    : bit positions of the header fields inside the beat
//   GRANT_W         : width of channel indices (covers up to 8 channels)
package usb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_HDR  = 3'b010,
        S_DATA = 3'b100
    } state_e;

    localparam logic [7:0]  HDR_SYNC_BYTE = 8'hA5;

    localparam int unsigned HDR_CH_LSB   = 0;
    localparam int unsigned HDR_CH_W     = 8;
    localparam int unsigned HDR_SYNC_LSB = 8;
    localparam int unsigned HDR_SYNC_W   = 8;

    localparam int unsigned GRANT_W = 3;

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// AXI-Stream bundle around the transmit arbiter.
//   s_axis_* : NUM_CH packed requester streams, channel 0 in the LSBs
//   m_axis_* : merged stream towards the FT60x FIFO controller
// Modports:
//   master : the arbiter (consumes s_axis, drives m_axis)
//   slave  : the surrounding logic (drives s_axis, consumes m_axis)
interface usb_tx_arbiter_if #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned FIFO_BUS_WIDTH = 2
);

    localparam int unsigned DW = FIFO_BUS_WIDTH * 8;

    logic [NUM_CH*DW-1:0]             s_axis_tdata;
    logic [NUM_CH*FIFO_BUS_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_CH*FIFO_BUS_WIDTH-1:0] s_axis_tstrb;
    logic [NUM_CH-1:0]                s_axis_tlast;
    logic [NUM_CH-1:0]                s_axis_tvalid;
    logic [NUM_CH-1:0]                s_axis_tready;

    logic [DW-1:0]                    m_axis_tdata;
    logic [FIFO_BUS_WIDTH-1:0]        m_axis_tkeep;
    logic [FIFO_BUS_WIDTH-1:0]        m_axis_tstrb;
    logic                             m_axis_tlast;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin priority encoder.
//   req_i        : request vector, one bit per channel
//   last_grant_i : channel granted most recently; search starts just above it
//   grant_o      : first requesting channel found, wrapping modulo NUM_CH
//   any_req_o    : at least one request is present
module usb_rr_arbiter import usb_pkg::*; #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]  req_i,
    input  logic [GRANT_W-1:0] last_grant_i,
    output logic [GRANT_W-1:0] grant_o,
    output logic               any_req_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        // Offsets 1..NUM_CH visit every channel once, ending at last_grant itself.
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (32'(last_grant_i) + i) % NUM_CH;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!found && (c == idx) && req_i[c]) begin
                    found   = 1'b1;
                    grant_o = GRANT_W'(c);
                end
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/usb_tx_arbiter.sv
// Merges NUM_CH AXI-Stream packet sources into one stream for the FT60x
// 245-FIFO controller. Each packet is preceded by a header beat carrying the
// sync byte and the granted channel index; channels are served round-robin.
//   usb_clk, rst_usbclk : clock and synchronous active-high reset
//   ch_en               : per-channel enable, masks new grants only
//   axis                : requester and merged streams (master modport)
//   busy                : FSM outside S_IDLE
//   grant_ch            : current or most recent granted channel
//   pkt_cnt             : completed packets, wrapping
module usb_tx_arbiter import usb_pkg::*; #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned FIFO_BUS_WIDTH = 2,
    parameter logic [7:0]  HDR_SYNC       = HDR_SYNC_BYTE
) (
    input  logic               usb_clk,
    input  logic               rst_usbclk,
    input  logic [NUM_CH-1:0]  ch_en,
    usb_tx_arbiter_if.master   axis,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_ch,
    output logic [31:0]        pkt_cnt
);

    localparam int unsigned DW = FIFO_BUS_WIDTH * 8;
    localparam int unsigned KW = FIFO_BUS_WIDTH;

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [GRANT_W-1:0] grant_ch_q, grant_ch_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;

    logic [NUM_CH-1:0]  req;
    logic [GRANT_W-1:0] arb_grant;
    logic               any_req;

    logic [DW-1:0]      sel_data;
    logic [KW-1:0]      sel_keep;
    logic [KW-1:0]      sel_strb;
    logic               sel_last;
    logic               sel_valid;

    assign req = axis.s_axis_tvalid & ch_en;

    usb_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (any_req)
    );

    // Mux of the granted channel's stream.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_strb  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_ch_q == GRANT_W'(c)) begin
                sel_data  = axis.s_axis_tdata[c*DW +: DW];
                sel_keep  = axis.s_axis_tkeep[c*KW +: KW];
                sel_strb  = axis.s_axis_tstrb[c*KW +: KW];
                sel_last  = axis.s_axis_tlast[c];
                sel_valid = axis.s_axis_tvalid[c];
            end
        end
    end

    // Output stream and source readiness.
    always_comb begin
        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tstrb  = '0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tvalid = 1'b0;
        axis.s_axis_tready = '0;
        unique case (state_q)
            S_IDLE: ;
            S_HDR: begin
                axis.m_axis_tvalid = 1'b1;
                axis.m_axis_tkeep  = '1;
                axis.m_axis_tstrb  = '1;
                axis.m_axis_tdata[HDR_SYNC_LSB +: HDR_SYNC_W] = HDR_SYNC;
                axis.m_axis_tdata[HDR_CH_LSB +: HDR_CH_W]     = HDR_CH_W'(grant_ch_q);
            end
            S_DATA: begin
                axis.m_axis_tdata  = sel_data;
                axis.m_axis_tkeep  = sel_keep;
                axis.m_axis_tstrb  = sel_strb;
                axis.m_axis_tlast  = sel_last;
                axis.m_axis_tvalid = sel_valid;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    axis.s_axis_tready[c] = (grant_ch_q == GRANT_W'(c)) & axis.m_axis_tready;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_ch_d   = grant_ch_q;
        pkt_cnt_d    = pkt_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_ch_d = arb_grant;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (axis.m_axis_tready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sel_valid && axis.m_axis_tready && sel_last) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_ch_q;
                    pkt_cnt_d    = pkt_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (rst_usbclk) begin
            state_q      <= S_IDLE;
            // NUM_CH-1 so the first search starts at channel 0.
            last_grant_q <= GRANT_W'(NUM_CH - 1);
            grant_ch_q   <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_ch_q   <= grant_ch_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_ch = grant_ch_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter (NUM_CH=4, 2-byte beats).
module tb_usb_tx_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned BW  = 2;

    logic        usb_clk = 1'b0;
    logic        rst_usbclk;
    logic [3:0]  ch_en;
    logic        busy;
    logic [2:0]  grant_ch;
    logic [31:0] pkt_cnt;

    always #5 usb_clk = ~usb_clk;

    usb_tx_arbiter_if #(.NUM_CH(NCH), .FIFO_BUS_WIDTH(BW)) axis_if ();

    usb_tx_arbiter #(
        .NUM_CH         (NCH),
        .FIFO_BUS_WIDTH (BW),
        .HDR_SYNC       (8'hA5)
    ) dut (
        .usb_clk    (usb_clk),
        .rst_usbclk (rst_usbclk),
        .ch_en      (ch_en),
        .axis       (axis_if),
        .busy       (busy),
        .grant_ch   (grant_ch),
        .pkt_cnt    (pkt_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-channel source queues.
    logic [15:0] src_d [NCH][8];
    bit          src_l [NCH][8];
    int          src_hd [NCH];
    int          src_n  [NCH];

    // Values seen at the falling edge of the last simulated cycle.
    logic        snap_tvalid;
    logic [15:0] snap_tdata;
    logic [3:0]  snap_s_tready;
    logic        snap_busy;
    logic [31:0] snap_pkt;
    logic [2:0]  snap_grant;

    logic [15:0] out_d [$];
    bit          out_l [$];
    logic [1:0]  out_k [$];
    logic [15:0] exp_d [$];
    bit          exp_l [$];

    task automatic src_clear();
        for (int c = 0; c < NCH; c++) begin
            src_hd[c] = 0;
            src_n[c]  = 0;
        end
    endtask

    task automatic src_push(input int ch, input logic [15:0] d, input bit l);
        src_d[ch][src_n[ch]] = d;
        src_l[ch][src_n[ch]] = l;
        src_n[ch]++;
    endtask

    task automatic drive_src();
        logic [NCH*16-1:0] d;
        logic [NCH*2-1:0]  k;
        logic [NCH-1:0]    v;
        logic [NCH-1:0]    l;
        d = '0; k = '0; v = '0; l = '0;
        for (int c = 0; c < NCH; c++) begin
            if (src_hd[c] < src_n[c]) begin
                v[c]          = 1'b1;
                d[c*16 +: 16] = src_d[c][src_hd[c]];
                l[c]          = src_l[c][src_hd[c]];
                k[c*2 +: 2]   = l[c] ? 2'b01 : 2'b11;
            end
        end
        axis_if.s_axis_tdata  = d;
        axis_if.s_axis_tkeep  = k;
        axis_if.s_axis_tstrb  = k;
        axis_if.s_axis_tlast  = l;
        axis_if.s_axis_tvalid = v;
    endtask

    // One clock: sample at the falling edge, then advance sources past the rising edge.
    task automatic tick();
        logic [NCH-1:0] hs;
        @(negedge usb_clk);
        snap_tvalid   = axis_if.m_axis_tvalid;
        snap_tdata    = axis_if.m_axis_tdata;
        snap_s_tready = axis_if.s_axis_tready;
        snap_busy     = busy;
        snap_pkt      = pkt_cnt;
        snap_grant    = grant_ch;
        hs = axis_if.s_axis_tvalid & axis_if.s_axis_tready;
        if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
            out_d.push_back(axis_if.m_axis_tdata);
            out_l.push_back(axis_if.m_axis_tlast);
            out_k.push_back(axis_if.m_axis_tkeep);
        end
        @(posedge usb_clk);
        #1;
        for (int c = 0; c < NCH; c++) if (hs[c]) src_hd[c]++;
        drive_src();
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while ((pkt_cnt != 32'(target)) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq(tag, pkt_cnt, 32'(target));
    endtask

    task automatic expect_beat(input logic [15:0] d, input bit l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic clear_streams();
        out_d.delete(); out_l.delete(); out_k.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic check_stream(input string tag);
        int n;
        check_eq({tag, "_len"}, 32'(out_d.size()), 32'(exp_d.size()));
        n = (out_d.size() < exp_d.size()) ? out_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_d%0d", tag, i), 32'(out_d[i]), 32'(exp_d[i]));
            check_eq($sformatf("%s_l%0d", tag, i), 32'(out_l[i]), 32'(exp_l[i]));
        end
    endtask

    task automatic pulse_reset();
        rst_usbclk = 1'b1;
        tick();
        rst_usbclk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_usbclk            = 1'b1;
        ch_en                 = 4'hF;
        axis_if.m_axis_tready = 1'b1;
        src_clear();
        src_push(0, 16'h0001, 1'b1);
        drive_src();

        // Reset holds everything idle even with a request present.
        tick();
        tick();
        check_eq("rst_busy",   32'(snap_busy), 32'h0);
        check_eq("rst_tvalid", 32'(snap_tvalid), 32'h0);
        check_eq("rst_tdata",  32'(snap_tdata), 32'h0);
        check_eq("rst_tready", 32'(snap_s_tready), 32'h0);
        check_eq("rst_pkt",    snap_pkt, 32'h0);
        check_eq("rst_grant",  32'(snap_grant), 32'h0);
        rst_usbclk = 1'b0;
        src_clear();
        drive_src();
        tick();

        // Single channel, 3 beats from ch1.
        clear_streams();
        src_push(1, 16'h1111, 1'b0);
        src_push(1, 16'h2222, 1'b0);
        src_push(1, 16'h3333, 1'b1);
        drive_src();
        tick();
        check_eq("t1_idle_tvalid", 32'(snap_tvalid), 32'h0);
        tick();
        check_eq("t1_hdr_tvalid", 32'(snap_tvalid), 32'h1);
        check_eq("t1_hdr_tdata",  32'(snap_tdata), 32'hA501);
        run_until("t1_done", 1, 20);
        expect_beat(16'hA501, 1'b0);
        expect_beat(16'h1111, 1'b0);
        expect_beat(16'h2222, 1'b0);
        expect_beat(16'h3333, 1'b1);
        check_stream("t1");
        check_eq("t1_grant", 32'(grant_ch), 32'h1);
        tick();
        check_eq("t1_busy_after", 32'(snap_busy), 32'h0);

        // Fairness between ch0 and ch2.
        src_clear();
        drive_src();
        pulse_reset();
        clear_streams();
        src_push(0, 16'h0A01, 1'b0); src_push(0, 16'h0A02, 1'b1);
        src_push(0, 16'h0A03, 1'b0); src_push(0, 16'h0A04, 1'b1);
        src_push(2, 16'h2A01, 1'b0); src_push(2, 16'h2A02, 1'b1);
        src_push(2, 16'h2A03, 1'b0); src_push(2, 16'h2A04, 1'b1);
        drive_src();
        run_until("t2_done", 4, 60);
        expect_beat(16'hA500, 1'b0); expect_beat(16'h0A01, 1'b0); expect_beat(16'h0A02, 1'b1);
        expect_beat(16'hA502, 1'b0); expect_beat(16'h2A01, 1'b0); expect_beat(16'h2A02, 1'b1);
        expect_beat(16'hA500, 1'b0); expect_beat(16'h0A03, 1'b0); expect_beat(16'h0A04, 1'b1);
        expect_beat(16'hA502, 1'b0); expect_beat(16'h2A03, 1'b0); expect_beat(16'h2A04, 1'b1);
        check_stream("t2");

        // Backpressure in header and mid-data on ch3.
        tick();
        clear_streams();
        src_clear();
        axis_if.m_axis_tready = 1'b0;
        src_push(3, 16'h3001, 1'b0);
        src_push(3, 16'h3002, 1'b0);
        src_push(3, 16'h3003, 1'b1);
        drive_src();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("t3_hdr_valid%0d", i), 32'(snap_tvalid), 32'h1);
            check_eq($sformatf("t3_hdr_data%0d", i), 32'(snap_tdata), 32'hA503);
            check_eq($sformatf("t3_hdr_srdy%0d", i), 32'(snap_s_tready), 32'h0);
        end
        axis_if.m_axis_tready = 1'b1;
        tick();
        tick();
        check_eq("t3_beat1_data", 32'(snap_tdata), 32'h3001);
        check_eq("t3_beat1_srdy", 32'(snap_s_tready), 32'h8);
        axis_if.m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t3_mid_valid%0d", i), 32'(snap_tvalid), 32'h1);
            check_eq($sformatf("t3_mid_data%0d", i), 32'(snap_tdata), 32'h3002);
            check_eq($sformatf("t3_mid_srdy%0d", i), 32'(snap_s_tready), 32'h0);
        end
        axis_if.m_axis_tready = 1'b1;
        run_until("t3_done", 5, 20);
        expect_beat(16'hA503, 1'b0);
        expect_beat(16'h3001, 1'b0);
        expect_beat(16'h3002, 1'b0);
        expect_beat(16'h3003, 1'b1);
        check_stream("t3");
        check_eq("t3_keep_hdr",  (out_k.size() > 0) ? 32'(out_k[0]) : 32'hDEAD, 32'h3);
        check_eq("t3_keep_last", (out_k.size() > 3) ? 32'(out_k[3]) : 32'hDEAD, 32'h1);

        // Enable masking: ch2 disabled, ch1 disabled mid-packet.
        src_clear();
        drive_src();
        pulse_reset();
        clear_streams();
        ch_en = 4'b1011;
        src_push(0, 16'h0B01, 1'b0); src_push(0, 16'h0B02, 1'b1);
        src_push(1, 16'h1B01, 1'b0); src_push(1, 16'h1B02, 1'b0); src_push(1, 16'h1B03, 1'b1);
        src_push(2, 16'h2B01, 1'b0); src_push(2, 16'h2B02, 1'b1);
        src_push(3, 16'h3B01, 1'b0); src_push(3, 16'h3B02, 1'b1);
        drive_src();
        repeat (7) tick();
        ch_en = 4'b1001;
        run_until("t4_done", 3, 40);
        repeat (4) tick();
        check_eq("t4_busy_end", 32'(snap_busy), 32'h0);
        check_eq("t4_ch2_untouched", 32'(src_hd[2]), 32'h0);
        expect_beat(16'hA500, 1'b0); expect_beat(16'h0B01, 1'b0); expect_beat(16'h0B02, 1'b1);
        expect_beat(16'hA501, 1'b0); expect_beat(16'h1B01, 1'b0); expect_beat(16'h1B02, 1'b0);
        expect_beat(16'h1B03, 1'b1);
        expect_beat(16'hA503, 1'b0); expect_beat(16'h3B01, 1'b0); expect_beat(16'h3B02, 1'b1);
        check_stream("t4");

        // Reset pulse during beat 2 of a ch3 packet.
        ch_en = 4'hF;
        src_clear();
        clear_streams();
        src_push(3, 16'h3C01, 1'b0); src_push(3, 16'h3C02, 1'b0);
        src_push(3, 16'h3C03, 1'b0); src_push(3, 16'h3C04, 1'b1);
        drive_src();
        repeat (3) tick();
        rst_usbclk = 1'b1;
        tick();
        rst_usbclk = 1'b0;
        src_push(0, 16'h0C01, 1'b1);
        drive_src();
        tick();
        check_eq("t5_post_tvalid", 32'(snap_tvalid), 32'h0);
        check_eq("t5_post_busy",   32'(snap_busy), 32'h0);
        check_eq("t5_post_pkt",    snap_pkt, 32'h0);
        tick();
        check_eq("t5_first_hdr", 32'(snap_tdata), 32'hA500);
        run_until("t5_done", 2, 40);
        expect_beat(16'hA503, 1'b0); expect_beat(16'h3C01, 1'b0); expect_beat(16'h3C02, 1'b0);
        expect_beat(16'hA500, 1'b0); expect_beat(16'h0C01, 1'b1);
        expect_beat(16'hA503, 1'b0); expect_beat(16'h3C03, 1'b0); expect_beat(16'h3C04, 1'b1);
        check_stream("t5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of transmit requesters, legal range 2..8.
REQ-002 Parameter FIFO_BUS_WIDTH, default 2: bytes per beat, matching the FT60x 245-FIFO controller; legal values 2 and 4.
REQ-003 Parameter HDR_SYNC, default 8'hA5: sync byte carried in the packet header beat.
REQ-004 Clocking and reset: one clock (usb_clk); reset rst_usbclk is synchronous and active-high.
REQ-005 usb_clk  in  1  sole clock.
REQ-006 rst_usbclk  in  1  synchronous active-high reset.
REQ-007 ch_en  in  NUM_CH  per-channel enable; a channel with its bit at 0 is never newly granted.
REQ-008 s_axis_tdata  in  NUM_CH*FIFO_BUS_WIDTH*8  channel data, packed, channel 0 in the LSBs.
REQ-009 s_axis_tkeep, s_axis_tstrb  in  NUM_CH*FIFO_BUS_WIDTH each  per-channel byte qualifiers, packed.
REQ-010 s_axis_tlast, s_axis_tvalid  in  NUM_CH each  per-channel last and valid.
REQ-011 s_axis_tready  out  NUM_CH  per-channel ready.
REQ-012 m_axis_tdata/tkeep/tstrb/tlast/tvalid  out  FIFO_BUS_WIDTH*8 / FIFO_BUS_WIDTH / FIFO_BUS_WIDTH / 1 / 1  merged stream to the FT60x controller.
REQ-013 m_axis_tready  in  1  ready from the FT60x controller.
REQ-014 busy  out  1  high in any state other than S_IDLE.
REQ-015 grant_ch  out  3  index of the current or most recent granted channel.
REQ-016 pkt_cnt  out  32  count of completed packets, wrapping.

Function
REQ-017 FSM states are S_IDLE, S_HDR and S_DATA; encoding is one-hot.
REQ-018 Request vector: req = s_axis_tvalid & ch_en.
REQ-019 Round-robin arbitration in S_IDLE: the grant goes to the first set req bit searching from last_grant+1 upward, wrapping modulo NUM_CH.
REQ-020 S_IDLE to S_HDR: on the cycle any req bit is high, the FSM registers the grant into grant_ch and moves to S_HDR.
REQ-021 Latency: the header is valid on the cycle after the request is seen.
REQ-022 Header beat contents in S_HDR:
- m_axis_tvalid=1, tlast=0, tkeep and tstrb all ones.
- tdata[15:8]=HDR_SYNC, tdata[7:0]=grant_ch zero-extended, all other tdata bits 0.
REQ-023 S_HDR to S_DATA: when m_axis_tready=1; the FSM holds S_HDR and the header stays stable while tready=0.
REQ-024 S_DATA datapath: m_axis data, keep, strb, last and valid are driven combinationally from the granted channel.
REQ-025 S_DATA readiness: s_axis_tready[grant_ch]=m_axis_tready; all other tready bits are 0.
REQ-026 S_DATA to S_IDLE: on m_axis_tvalid & m_axis_tready & m_axis_tlast; the same cycle sets last_grant<=grant_ch and increments pkt_cnt by 1.
REQ-027 Source valid low in S_DATA: m_axis_tvalid=0 and the FSM holds S_DATA (no timeout).
REQ-028 ch_en cleared mid-packet: the current packet completes normally; the channel is excluded only from later grants.
REQ-029 Single-beat packet (tlast on the first data beat) is legal: the output is header + 1 beat.
REQ-030 The next arbitration takes place in the S_IDLE cycle following tlast, so each packet costs at least 1 idle cycle plus 1 header cycle of overhead.
REQ-031 In S_IDLE and S_HDR, all s_axis_tready bits are 0.
REQ-032 In S_IDLE, m_axis_tvalid=0 and m_axis_tdata/keep/strb/tlast are 0.
REQ-033 pkt_cnt wraps from 32'hFFFFFFFF to 0 with no flag.

Reset
REQ-034 Reset values while rst_usbclk=1:
- state S_IDLE, last_grant=NUM_CH-1 (channel 0 is favoured first), grant_ch=0, pkt_cnt=0.
- all s_axis_tready=0, m_axis_tvalid=0, busy=0.
REQ-035 Reset asserted mid-packet aborts the packet immediately with no tlast emitted; the first post-reset grant follows REQ-034.

Structure
REQ-036 Shared package usb_pkg holds the state encodings, HDR_SYNC, and the header field positions.
REQ-037 Sub-module usb_rr_arbiter (NUM_CH-wide round-robin priority encoder: req, last_grant to grant index and any_req) is combinational and instantiated once.

Verification
REQ-038 Single channel: reset, then ch1 sends 3 beats 16'h1111/2222/3333 (tlast on the third) with tready=1 -> output A501, 1111, 2222, 3333; tlast on 3333; pkt_cnt=1.
REQ-039 Fairness: ch0 and ch2 both hold continuous 2-beat packets -> grant order 0,2,0,2; header low bytes 00,02,00,02.
REQ-040 Backpressure: m_axis_tready=0 for 5 cycles during S_HDR, then again mid-data -> header and data held stable, no beat lost or duplicated, and s_axis_tready of the granted channel mirrors m_axis_tready.
REQ-041 Enable masking: ch_en=4'b1011 with all channels requesting -> ch2 is never granted; clearing ch_en[1] during ch1's packet still completes that packet with tlast.
REQ-042 Reset mid-packet: rst_usbclk pulses for 1 cycle during beat 2 of a ch3 packet -> the next cycle has m_axis_tvalid=0, busy=0 and pkt_cnt=0, and the first following grant goes to ch0 when ch0 and ch3 both request.
